// File: rtl/switch_pkt_tx.sv
// Packet transmitter toward a switch port: buffers payload words, then frames DA, SA, LEN, payload.
// Optional parity trailer byte after the payload when SW_TX_PARITY_EN is defined.
module switch_pkt_tx #(
  parameter int WORD_WIDTH  = 8,
  parameter int MAX_PAYLOAD = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              pld_wr_en,
  input  logic [WORD_WIDTH-1:0]             pld_wr_data,
  input  logic                              start,
  input  logic [WORD_WIDTH-1:0]             pkt_da,
  input  logic [WORD_WIDTH-1:0]             pkt_sa,
  input  logic                              read_out,
  output logic                              sw_enable_in,
  output logic [WORD_WIDTH-1:0]             data_in,
  output logic                              tx_busy,
  output logic                              tx_done,
  output logic                              tx_err,
  output logic [$clog2(MAX_PAYLOAD):0]      pld_cnt
);
  localparam int CW = $clog2(MAX_PAYLOAD) + 1;
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

`ifdef SW_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, WAIT_SW, DA, SA, LEN, PLD, PAR, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, WAIT_SW, DA, SA, LEN, PLD, GAP} state_t;
`endif

  state_t                state, state_nxt;
  logic [WORD_WIDTH-1:0] pld_mem [MAX_PAYLOAD];
  logic [CW-1:0]         cnt, cnt_nxt, idx, len_q;
  logic [WORD_WIDTH-1:0] da_q, sa_q, par_q;
  logic                  err_q;
  logic                  wr_ok, accept, reject, last;

  assign wr_ok   = (state == IDLE) && pld_wr_en && (cnt < CW'(MAX_PAYLOAD));
  // A write in the same cycle as start lands first, so it counts toward LEN.
  assign cnt_nxt = cnt + {{(CW-1){1'b0}}, wr_ok};
  assign accept  = (state == IDLE) && start && (cnt_nxt != '0);
  assign reject  = (state == IDLE) && start && (cnt_nxt == '0);
  assign last    = (idx == len_q - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT_SW;
      WAIT_SW: if (!read_out) state_nxt = DA;
      DA:      state_nxt = SA;
      SA:      state_nxt = LEN;
      LEN:     state_nxt = PLD;
`ifdef SW_TX_PARITY_EN
      PLD:     if (last) state_nxt = PAR;
      PAR:     state_nxt = GAP;
`else
      PLD:     if (last) state_nxt = GAP;
`endif
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sw_enable_in = 1'b0;
    data_in      = '0;
    tx_busy      = (state != IDLE);
    tx_done      = (state == GAP);
    case (state)
      DA:  begin sw_enable_in = 1'b1; data_in = da_q; end
      SA:  begin sw_enable_in = 1'b1; data_in = sa_q; end
      LEN: begin sw_enable_in = 1'b1; data_in = WORD_WIDTH'(len_q); end
      PLD: begin sw_enable_in = 1'b1; data_in = pld_mem[idx[AW-1:0]]; end
`ifdef SW_TX_PARITY_EN
      PAR: begin sw_enable_in = 1'b1; data_in = par_q; end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) pld_mem[cnt[AW-1:0]] <= pld_wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      len_q <= '0;
      da_q  <= '0;
      sa_q  <= '0;
      par_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= reject;
      cnt   <= (state == GAP) ? '0 : cnt_nxt;
      if (accept) begin
        da_q  <= pkt_da;
        sa_q  <= pkt_sa;
        len_q <= cnt_nxt;
        idx   <= '0;
        par_q <= pkt_da ^ pkt_sa ^ WORD_WIDTH'(cnt_nxt);
      end else if (state == PLD) begin
        idx   <= idx + CW'(1);
        par_q <= par_q ^ pld_mem[idx[AW-1:0]];
      end
    end
  end

  assign tx_err  = err_q;
  assign pld_cnt = cnt;

endmodule

// File: doc/switch_pkt_tx.md
SWITCH_PKT_TX -- requirements
Module: switch_pkt_tx

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, the byte width of every data path.
REQ-002 SHALL have parameter MAX_PAYLOAD, default 16, the payload buffer depth in words.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; synchronous and active-low.
REQ-005 SHALL have port pld_wr_en, input, 1 bit, which writes pld_wr_data into the payload buffer.
REQ-006 SHALL have port pld_wr_data, input, WORD_WIDTH bits, the payload word.
REQ-007 SHALL have port start, input, 1 bit, the transmit request, sampled only in IDLE.
REQ-008 SHALL have ports pkt_da and pkt_sa, input, WORD_WIDTH bits each, the destination and source address, captured on an accepted start.
REQ-009 SHALL have port read_out, input, 1 bit, the switch busy-reading indication.
REQ-010 SHALL have port sw_enable_in, output, 1 bit, the packet framing strobe to the switch.
REQ-011 SHALL have port data_in, output, WORD_WIDTH bits, the packet byte to the switch.
REQ-012 SHALL have port tx_busy, output, 1 bit, high whenever state is not IDLE.
REQ-013 SHALL have port tx_done, output, 1 bit, a one-cycle pulse when a packet completes.
REQ-014 SHALL have port tx_err, output, 1 bit, a one-cycle pulse when a start is rejected.
REQ-015 SHALL have port pld_cnt, output, clog2(MAX_PAYLOAD)+1 bits, the number of words buffered.

Function
REQ-016 SHALL implement the FSM IDLE -> WAIT_SW -> DA -> SA -> LEN -> PLD -> GAP -> IDLE, one byte per cycle in DA..PLD.
REQ-017 SHALL, in IDLE, accept start only when 1 <= pld_cnt <= MAX_PAYLOAD; on accept it latches pkt_da/pkt_sa, sets LEN = pld_cnt and goes to WAIT_SW.
REQ-018 SHALL, in IDLE, reject a start when pld_cnt == 0: pulse tx_err the next cycle and remain in IDLE.
REQ-019 SHALL remain in WAIT_SW while read_out == 1 and enter DA on the first cycle read_out == 0.
REQ-020 SHALL drive sw_enable_in = 1 in states DA, SA, LEN and PLD, and 0 in all other states.
REQ-021 SHALL drive data_in = DA, SA, LEN, then payload[0..LEN-1] in write order, with data_in = 0 whenever sw_enable_in == 0.
REQ-022 SHALL give a latency of 2 cycles from an accepted start (with read_out == 0) to the first sw_enable_in == 1 cycle.
REQ-023 SHALL hold GAP for exactly one cycle with sw_enable_in == 0, pulse tx_done in that GAP cycle, and clear the buffer (pld_cnt = 0).
REQ-024 SHALL append pld_wr_en writes in IDLE only; it ignores writes in every other state and ignores writes when pld_cnt == MAX_PAYLOAD (no wrap, no overwrite).
REQ-025 SHALL ignore start in any state other than IDLE, with no tx_err.
REQ-026 SHALL not sample read_out after DA; a rise of read_out mid-packet does not stall transmission.
REQ-027 SHALL, on simultaneous pld_wr_en and an accepted start in IDLE, take the write first, so LEN includes that word.

Reset
REQ-028 SHALL, with rst_n low at a clock edge, set: state IDLE, sw_enable_in 0, data_in 0, tx_busy 0, tx_done 0, tx_err 0, pld_cnt 0.
REQ-029 SHALL, on reset mid-packet, drop sw_enable_in on the next edge and discard the packet, with no tx_done.

Configuration
REQ-030 SHALL, with macro SW_TX_PARITY_EN defined, insert a PAR state between PLD and GAP that emits one byte with sw_enable_in = 1, equal to the XOR of DA, SA, LEN and all payload bytes; LEN is unchanged.
REQ-031 SHALL, without SW_TX_PARITY_EN, have no PAR state and no trailer byte.

Verification
REQ-032 SHALL cover: write 3 words 0x11,0x22,0x33; start with DA=0x02, SA=0x05, read_out=0 -> sw_enable_in high for 6 cycles with data 02,05,03,11,22,33, then tx_done, pld_cnt=0.
REQ-033 SHALL cover: start with pld_cnt=0 -> tx_err one pulse, sw_enable_in stays 0, state IDLE.
REQ-034 SHALL cover: read_out held high 5 cycles after start -> sw_enable_in stays 0 for those cycles, DA appears the cycle after read_out falls.
REQ-035 SHALL cover: write 17 words with MAX_PAYLOAD=16 -> pld_cnt=16, LEN byte=0x10, last payload byte = 16th word.
REQ-036 SHALL cover: rst_n low during the PLD state -> sw_enable_in 0 next cycle, no tx_done, pld_cnt=0.
REQ-037 SHALL cover, with SW_TX_PARITY_EN: DA=0x01, SA=0x02, payload 0x04 -> bytes 01,02,01,04,06.
